// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller bridging RV32I loads/stores to a
// req/ack word bus with alignment/legality checks, lane steering and timeout abort.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_mem,
  input  logic        mem_wr_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic        stall_mem,
  output logic [31:0] load_data_wb,
  output logic        done_pulse,
  output logic        misalign_fault,
  output logic        illegal_fault,
  output logic        bus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, ld_q, ld_d, lane, fmt;
  logic [2:0]  f3_q;
  logic        we_q, mis_q, ill_q, bf_q;
  logic [3:0]  be_q, be_n;
  logic [31:0] wd_n;
  logic        req, legal, aligned, accept, busy, timeout;
  always_comb begin
    req     = (state_q == IDLE) && mem_en_mem;
    legal   = mem_wr_mem ? (!funct3_mem[2] && funct3_mem[1:0] != 2'd3)
                         : (funct3_mem != 3'd3 && funct3_mem != 3'd6 && funct3_mem != 3'd7);
    aligned = (funct3_mem[1:0] == 2'd2) ? (addr_mem[1:0] == 2'd0) :
              (funct3_mem[1:0] == 2'd1) ? !addr_mem[0] : 1'b1;
    accept  = req && legal && aligned;
    busy    = (state_q == BUSY);
    timeout = (cnt_q == 8'(TIMEOUT - 1));
    be_n    = (funct3_mem[1:0] == 2'd0) ? (4'b0001 << addr_mem[1:0]) :
              (funct3_mem[1:0] == 2'd1) ? (4'b0011 << addr_mem[1:0]) : 4'b1111;
    wd_n    = (funct3_mem[1:0] == 2'd0) ? {4{wdata_mem[7:0]}} :
              (funct3_mem[1:0] == 2'd1) ? {2{wdata_mem[15:0]}} : wdata_mem;
    lane    = bus_rdata >> {addr_q[1:0], 3'b000};
    fmt     = (f3_q == 3'd0) ? {{24{lane[7]}}, lane[7:0]} :
              (f3_q == 3'd1) ? {{16{lane[15]}}, lane[15:0]} :
              (f3_q == 3'd4) ? {24'd0, lane[7:0]} :
              (f3_q == 3'd5) ? {16'd0, lane[15:0]} : lane;
    // A timed-out load must not leave a stale value looking like a result.
    ld_d    = (busy && !we_q) ? (bus_ack ? fmt : timeout ? 32'd0 : ld_q) : ld_q;
    state_d = (state_q == IDLE) ? (accept ? BUSY : IDLE) :
              busy ? ((bus_ack || timeout) ? DONE : BUSY) : IDLE;
    cnt_d   = busy ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      bf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      mis_q   <= req && legal && !aligned;
      ill_q   <= req && !legal;
      bf_q    <= busy && !bus_ack && timeout;
      if (accept) begin
        addr_q  <= addr_mem;
        wdata_q <= wd_n;
        f3_q    <= funct3_mem;
        we_q    <= mem_wr_mem;
        be_q    <= be_n;
      end
    end
  end
  assign stall_mem      = accept || busy;
  assign bus_req        = busy;
  assign bus_we         = we_q;
  assign bus_addr       = {addr_q[31:2], 2'b00};
  assign bus_be         = be_q;
  assign bus_wdata      = wdata_q;
  assign load_data_wb   = ld_q;
  assign done_pulse     = (state_q == DONE);
  assign misalign_fault = mis_q;
  assign illegal_fault  = ill_q;
  assign bus_fault      = bf_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl with TIMEOUT=4.
module tb_dmem_ctrl;
  logic        clk, rst, mem_en_mem, mem_wr_mem, bus_ack;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_mem, wdata_mem, bus_rdata;
  logic        stall_mem, done_pulse, misalign_fault, illegal_fault, bus_fault, bus_req, bus_we;
  logic [31:0] load_data_wb, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [31:0] ld; logic bf;} exp_t;
  exp_t sb[$];
  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_en_mem(mem_en_mem), .mem_wr_mem(mem_wr_mem),
    .funct3_mem(funct3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .stall_mem(stall_mem), .load_data_wb(load_data_wb), .done_pulse(done_pulse),
    .misalign_fault(misalign_fault), .illegal_fault(illegal_fault), .bus_fault(bus_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic o, input logic e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                        input int ack_at, input int exp_n, input logic [3:0] ebe,
                        input logic [31:0] eaddr, ewd, eld, input logic ebf);
    int n;
    exp_t e;
    sb.push_back('{eld, ebf});
    mem_en_mem = 1'b1; mem_wr_mem = wr; funct3_mem = f3; addr_mem = a; wdata_mem = wd;
    #1;
    chk1("stall_accept", stall_mem, 1'b1);
    tick;
    mem_en_mem = 1'b0;
    chk1("bus_req_busy", bus_req, 1'b1);
    chk32("bus_addr", bus_addr, eaddr);
    chk32("bus_be", {28'd0, bus_be}, {28'd0, ebe});
    chk1("bus_we", bus_we, wr);
    if (wr) chk32("bus_wdata", bus_wdata, ewd);
    n = 0;
    while (!done_pulse && n < 20) begin
      bus_ack = (n == ack_at);
      bus_rdata = rd;
      tick;
      bus_ack = 1'b0;
      n++;
    end
    chk32("busy_cycles", n, exp_n);
    chk1("done_pulse", done_pulse, 1'b1);
    chk1("stall_done", stall_mem, 1'b0);
    chk1("bus_req_done", bus_req, 1'b0);
    e = sb.pop_front();
    chk32("load_data_wb", load_data_wb, e.ld);
    chk1("bus_fault", bus_fault, e.bf);
    tick;
    chk1("done_clear", done_pulse, 1'b0);
    chk1("fault_clear", bus_fault, 1'b0);
  endtask
  initial begin
    exp_t e;
    int reqs;
    rst = 1'b1; mem_en_mem = 0; mem_wr_mem = 0; funct3_mem = 0; addr_mem = 0;
    wdata_mem = 0; bus_rdata = 0; bus_ack = 0;
    tick; tick;
    chk1("rst_stall", stall_mem, 1'b0);
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_we", bus_we, 1'b0);
    chk32("rst_addr", bus_addr, 32'd0);
    chk32("rst_be", {28'd0, bus_be}, 32'd0);
    chk32("rst_wdata", bus_wdata, 32'd0);
    chk32("rst_ld", load_data_wb, 32'd0);
    chk1("rst_done", done_pulse, 1'b0);
    rst = 1'b0;
    tick;
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0);
    access(1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 0, 1, 4'b1100, 32'h200, 32'hBEEFBEEF, 32'hFFFFFF80, 1'b0);
    mem_en_mem = 1'b1; mem_wr_mem = 1'b0; funct3_mem = 3'd2; addr_mem = 32'h101;
    #1;
    chk1("mis_stall", stall_mem, 1'b0);
    chk1("mis_req0", bus_req, 1'b0);
    tick;
    mem_en_mem = 1'b0;
    chk1("mis_pulse", misalign_fault, 1'b1);
    chk1("mis_not_ill", illegal_fault, 1'b0);
    chk1("mis_req1", bus_req, 1'b0);
    tick;
    chk1("mis_clear", misalign_fault, 1'b0);
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'h5A5A5A5A, -1, 4, 4'b1111, 32'h300, 32'h0, 32'h0, 1'b1);
    access(1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEF00D, 3, 4, 4'b1111, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1'b0, 3'd1, 32'h0, 32'h0, 32'h00008001, 1, 2, 4'b0011, 32'h0, 32'h0, 32'hFFFF8001, 1'b0);
    access(1'b0, 3'd4, 32'h101, 32'h0, 32'h00008000, 0, 1, 4'b0010, 32'h100, 32'h0, 32'h00000080, 1'b0);
    access(1'b1, 3'd0, 32'h1, 32'h000000A5, 32'h0, 0, 1, 4'b0010, 32'h0, 32'hA5A5A5A5, 32'h00000080, 1'b0);
    access(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h0, 2, 3, 4'b1111, 32'h20, 32'hDEADBEEF, 32'h00000080, 1'b0);
    mem_en_mem = 1'b1; mem_wr_mem = 1'b0; funct3_mem = 3'd3; addr_mem = 32'h0;
    #1;
    chk1("ill_stall", stall_mem, 1'b0);
    tick;
    mem_en_mem = 1'b0;
    chk1("ill_pulse", illegal_fault, 1'b1);
    chk1("ill_req", bus_req, 1'b0);
    tick;
    chk1("ill_clear", illegal_fault, 1'b0);
    mem_en_mem = 1'b1; mem_wr_mem = 1'b1; funct3_mem = 3'd5; addr_mem = 32'h1;
    tick;
    mem_en_mem = 1'b0;
    chk1("prio_ill", illegal_fault, 1'b1);
    chk1("prio_no_mis", misalign_fault, 1'b0);
    chk1("prio_req", bus_req, 1'b0);
    tick;
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    tick;
    bus_ack = 1'b0;
    chk1("stray_ack_done", done_pulse, 1'b0);
    chk32("stray_ack_ld", load_data_wb, 32'h00000080);
    mem_en_mem = 1'b1; mem_wr_mem = 1'b0; funct3_mem = 3'd2; addr_mem = 32'h400;
    tick;
    mem_en_mem = 1'b0;
    chk1("rb_busy", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rb_req_drop", bus_req, 1'b0);
    chk1("rb_stall", stall_mem, 1'b0);
    tick;
    rst = 1'b0;
    chk1("rb_no_bf", bus_fault, 1'b0);
    chk1("rb_no_done", done_pulse, 1'b0);
    chk32("rb_ld", load_data_wb, 32'd0);
    tick;
    access(1'b0, 3'd5, 32'h2, 32'h0, 32'hABCD0000, 0, 1, 4'b1100, 32'h0, 32'h0, 32'h0000ABCD, 1'b0);
    sb.push_back('{32'h11223344, 1'b0});
    mem_en_mem = 1'b1; mem_wr_mem = 1'b0; funct3_mem = 3'd2; addr_mem = 32'h40;
    bus_rdata = 32'h11223344; bus_ack = 1'b1;
    reqs = 0;
    tick;
    if (bus_req) reqs++;
    tick;
    chk1("b2b_done", done_pulse, 1'b1);
    chk1("b2b_stall_done", stall_mem, 1'b0);
    e = sb.pop_front();
    chk32("b2b_ld", load_data_wb, e.ld);
    tick;
    mem_en_mem = 1'b0; bus_ack = 1'b0;
    if (bus_req) reqs++;
    tick;
    if (bus_req) reqs++;
    chk32("b2b_one_txn", reqs, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max cycles in BUSY awaiting bus_ack before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_en_mem  input  1  MEM-stage memory access request.
REQ-005 mem_wr_mem  input  1  1=store, 0=load; valid only with mem_en_mem.
REQ-006 funct3_mem  input  3  access size/sign (RV32I load/store funct3).
REQ-007 addr_mem  input  32  byte address (ALU result).
REQ-008 wdata_mem  input  32  store data (rs2 value, LSB-justified).
REQ-009 stall_mem  output  1  holds IF..MEM stages while access is outstanding.
REQ-010 load_data_wb  output  32  aligned, sign/zero-extended load result.
REQ-011 done_pulse  output  1  one-cycle pulse when an access retires (success or fault).
REQ-012 misalign_fault, illegal_fault, bus_fault  output  1 each  one-cycle fault pulses.
REQ-013 bus_req, bus_we  output  1 each  external bus request / write strobe.
REQ-014 bus_addr  output  32  word address, bits [1:0] forced 0.
REQ-015 bus_be  output  4  byte enables; bus_wdata  output  32  lane-replicated store data.
REQ-016 bus_rdata  input  32  read data, valid with bus_ack; bus_ack  input  1  bus completion.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE, mem_en_mem=1, legal and aligned: latch addr/funct3/we/wdata, assert stall_mem combinationally this cycle, go BUSY.
REQ-019 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; violation -> misalign_fault pulse next cycle, no bus activity, stall_mem=0, stay IDLE.
REQ-020 Legal funct3: load 0,1,2,4,5; store 0,1,2; others -> illegal_fault pulse next cycle, no bus activity, stay IDLE; illegal takes priority over misalign.
REQ-021 BUSY: bus_req=1, bus_we/bus_addr/bus_be/bus_wdata held constant from latched values; stall_mem=1.
REQ-022 bus_be: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111; loads drive the same mask.
REQ-023 bus_wdata: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-024 BUSY, bus_ack=1: capture formatted bus_rdata (loads only) into load_data_wb, drop bus_req next cycle, go DONE.
REQ-025 Load formatting: select lane by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-026 Timeout counter cleared on BUSY entry, increments each BUSY cycle without ack; at count TIMEOUT-1 with no ack -> go DONE, bus_fault pulse, load_data_wb=0 for loads.
REQ-027 bus_ack on the same cycle counter reaches TIMEOUT-1 SHALL count as success (no bus_fault).
REQ-028 DONE: stall_mem=0, done_pulse=1, go IDLE unconditionally; mem_en_mem in DONE SHALL NOT start a new access.
REQ-029 Stores leave load_data_wb unchanged; load_data_wb holds until next completed load.
REQ-030 bus_ack outside BUSY SHALL be ignored.
REQ-031 Load-to-use latency (ack in first BUSY cycle): accept cycle N, BUSY N+1, DONE N+2, pipeline advances at end of N+2.

Reset
REQ-032 On rst: state IDLE, counter 0, stall_mem=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data_wb=0, all pulses 0.
REQ-033 rst asserted in BUSY SHALL drop bus_req immediately (asynchronously); the access is abandoned with no fault pulse.

Verification
REQ-034 LB addr=0x103, bus_rdata=0x80FFFFFF, ack 1st BUSY cycle -> bus_be=4'b1000, load_data_wb=0xFFFFFF80, done_pulse in cycle N+2.
REQ-035 SH addr=0x202, wdata=0x0000BEEF -> bus_we=1, bus_be=4'b1100, bus_wdata=0xBEEFBEEF, bus_addr=0x200.
REQ-036 LW addr=0x101 -> misalign_fault one cycle, bus_req never asserted, stall_mem=0.
REQ-037 LW with bus_ack withheld, TIMEOUT=4 -> bus_req high 4 cycles, bus_fault pulse, load_data_wb=0, back to IDLE.
REQ-038 rst asserted mid-BUSY -> bus_req=0 same cycle, state IDLE; subsequent LHU addr=0x2, rdata=0xABCD0000 -> load_data_wb=0x0000ABCD.
REQ-039 funct3=3 load -> illegal_fault pulse, no bus traffic; back-to-back mem_en_mem held through DONE -> exactly one bus transaction.
